// File: rtl/crest_seq_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : crest_seq_pkg
//  Purpose  : Shared types and constants for the CREsT sequential control FSM:
//             state encoding, transform mode codes and the default LFSR taps.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package crest_seq_pkg;

  // State codes are visible on the state output, so the values are fixed.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_ROL  = 2'b01;
  localparam logic [1:0] MODE_INV  = 2'b10;
  localparam logic [1:0] MODE_LFSR = 2'b11;

  localparam logic [7:0] DEF_LFSR_TAP = 8'hB8;

endpackage : crest_seq_pkg
`default_nettype wire

// File: rtl/crest_seq_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : crest_seq_fsm_if
//  Purpose  : Request/acknowledge control bus of the CREsT sequential FSM.
//  Ports    : master drives start/abort/en/ack/mode/din and observes
//             busy/done/err/cnt/dout/state; slave is the mirror image.
//  Revision : 1.0  initial release
// ============================================================================
interface crest_seq_fsm_if #(
  parameter int IN_W  = 8,
  parameter int CNT_W = 5,
  parameter int OUT_W = 8
);
  logic             start;
  logic             abort;
  logic             en;
  logic             ack;
  logic [1:0]       mode;
  logic [IN_W-1:0]  din;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] dout;
  logic [2:0]       state;

  modport master (
    output start, abort, en, ack, mode, din,
    input  busy, done, err, cnt, dout, state
  );

  modport slave (
    input  start, abort, en, ack, mode, din,
    output busy, done, err, cnt, dout, state
  );
endinterface : crest_seq_fsm_if
`default_nettype wire

// File: rtl/crest_seq_fsm_xform.sv
`default_nettype none
// ============================================================================
//  Module   : crest_seq_xform
//  Purpose  : Combinational next-value function of the data register.
//             00 hold, 01 rotate-left-1, 10 invert, 11 Fibonacci-style LFSR
//             step (shift left, feedback = parity of dout & LFSR_TAP).
//  Ports    : dout_i  current data register
//             mode_i  latched transform mode
//             dout_o  transformed value
//  Revision : 1.0  initial release
// ============================================================================
module crest_seq_xform
  import crest_seq_pkg::*;
#(
  parameter int               OUT_W    = 8,
  parameter logic [OUT_W-1:0] LFSR_TAP = OUT_W'(DEF_LFSR_TAP)
) (
  input  logic [OUT_W-1:0] dout_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] dout_o
);

  always_comb begin
    dout_o = dout_i;
    case (mode_i)
      MODE_HOLD: dout_o = dout_i;
      MODE_ROL:  dout_o = {dout_i[OUT_W-2:0], dout_i[OUT_W-1]};
      MODE_INV:  dout_o = ~dout_i;
      // An all-zero register stays zero here; that lockup is intentional.
      MODE_LFSR: dout_o = {dout_i[OUT_W-2:0], ^(dout_i & LFSR_TAP)};
      default:   dout_o = dout_i;
    endcase
  end

endmodule : crest_seq_xform
`default_nettype wire

// File: rtl/crest_seq_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : crest_seq_fsm
//  Purpose  : Reference sequential control FSM for the CREsT benchmark flow.
//             IDLE captures run length/seed/mode on start, LOAD clears the
//             step counter, RUN transforms the data register once per enabled
//             cycle until len steps are done, DONE/ERR wait for ack.
//  Ports    : CK        clock, rising edge
//             CLR       synchronous active-low reset
//             bus       control interface (slave side)
//             scan_en   shift enable          (SCAN_CHAIN_EN only)
//             scan_in   serial input          (SCAN_CHAIN_EN only)
//             scan_out  serial output, dout[0] (SCAN_CHAIN_EN only)
//  Macro    : SCAN_CHAIN_EN adds a full scan chain over every flop, order
//             state[2:0], mode_r, len, cnt, dout (MSB first each).
//  Revision : 1.0  initial release
// ============================================================================
module crest_seq_fsm
  import crest_seq_pkg::*;
#(
  parameter int               IN_W     = 8,
  parameter int               CNT_W    = 5,
  parameter int               OUT_W    = 8,
  parameter logic [OUT_W-1:0] LFSR_TAP = OUT_W'(DEF_LFSR_TAP)
) (
  input  logic           CK,
  input  logic           CLR,
  crest_seq_fsm_if.slave bus
`ifdef SCAN_CHAIN_EN
  ,
  input  logic           scan_en,
  input  logic           scan_in,
  output logic           scan_out
`endif
);

  logic [2:0]       state_q, state_d;
  logic [1:0]       mode_q,  mode_d;
  logic [CNT_W-1:0] len_q,   len_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [OUT_W-1:0] dout_q,  dout_d;
  logic [OUT_W-1:0] xf_dout;

  crest_seq_xform #(
    .OUT_W    (OUT_W),
    .LFSR_TAP (LFSR_TAP)
  ) u_xform (
    .dout_i (dout_q),
    .mode_i (mode_q),
    .dout_o (xf_dout)
  );

  // State register (together with the datapath registers it controls).
  always_ff @(posedge CK) begin
    if (!CLR) begin
      state_q <= IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state and datapath next-value logic.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d   = bus.din[CNT_W-1:0];
          dout_d  = bus.din[OUT_W-1:0];
          mode_d  = bus.mode;
          state_d = (bus.din[CNT_W-1:0] == '0) ? ERR : LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = bus.abort ? IDLE : RUN;
      end
      RUN: begin
        // abort wins over en and leaves cnt/dout untouched.
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.en) begin
          cnt_d  = cnt_q + CNT_W'(1);
          dout_d = xf_dout;
          // Compare before the increment so len = 2^CNT_W-1 never wraps cnt.
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE, ERR: begin
        if (bus.ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        // Unreachable codes recover to a clean IDLE.
        state_d = IDLE;
        mode_d  = '0;
        len_d   = '0;
        cnt_d   = '0;
        dout_d  = '0;
      end
    endcase
`ifdef SCAN_CHAIN_EN
    // Shifting overrides every functional update; reset still wins in the
    // register process.
    if (scan_en) begin
      {state_d, mode_d, len_d, cnt_d, dout_d} =
        {scan_in, state_q, mode_q, len_q, cnt_q, dout_q[OUT_W-1:1]};
    end
`endif
  end

  // Output decode: purely from registered state, no input-to-output path.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.err  = 1'b0;
    case (state_q)
      LOAD, RUN: bus.busy = 1'b1;
      DONE:      bus.done = 1'b1;
      ERR:       bus.err  = 1'b1;
      default:   ;
    endcase
  end

  assign bus.state = state_q;
  assign bus.cnt   = cnt_q;
  assign bus.dout  = dout_q;

`ifdef SCAN_CHAIN_EN
  assign scan_out = dout_q[0];
`endif

endmodule : crest_seq_fsm
`default_nettype wire

// File: tb/tb_crest_seq_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crest_seq_fsm
//  Purpose  : Self-checking bench for crest_seq_fsm: directed scenarios plus
//             randomized traffic compared every cycle against a behavioural
//             model of the run protocol.
//  Revision : 1.0  initial release
// ============================================================================
module tb_crest_seq_fsm;

  localparam int IN_W  = 8;
  localparam int CNT_W = 5;
  localparam int OUT_W = 8;
  localparam int TAP   = 'hB8;
  localparam int CMOD  = 1 << CNT_W;
  localparam int OMOD  = 1 << OUT_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  crest_seq_fsm_if #(.IN_W(IN_W), .CNT_W(CNT_W), .OUT_W(OUT_W)) bus ();

`ifdef SCAN_CHAIN_EN
  localparam int CHAIN_W = 3 + 2 + 2 * CNT_W + OUT_W;
  logic scan_en = 1'b0;
  logic scan_in = 1'b0;
  logic scan_out;
`endif

  crest_seq_fsm #(
    .IN_W     (IN_W),
    .CNT_W    (CNT_W),
    .OUT_W    (OUT_W),
    .LFSR_TAP (8'hB8)
  ) dut (
    .CK  (clk),
    .CLR (rst_n),
    .bus (bus)
`ifdef SCAN_CHAIN_EN
    ,
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: state as an integer phase, data as plain integers.
  int m_state = 0;
  int m_len   = 0;
  int m_cnt   = 0;
  int m_dout  = 0;
  int m_mode  = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_xf(input int d, input int md);
    case (md)
      1:       return ((d * 2) % OMOD) + (d / (OMOD / 2));
      2:       return (OMOD - 1) - d;
      3:       return ((d * 2) % OMOD) + ($countones(d & TAP) % 2);
      default: return d;
    endcase
  endfunction

  task automatic model_step();
    if (rst_n === 1'b0) begin
      m_state = 0; m_len = 0; m_cnt = 0; m_dout = 0; m_mode = 0;
    end else begin
      case (m_state)
        0: if (bus.start) begin
             m_len   = int'(bus.din) % CMOD;
             m_dout  = int'(bus.din) % OMOD;
             m_mode  = int'(bus.mode);
             m_state = (m_len == 0) ? 4 : 1;
           end
        1: begin
             m_cnt   = 0;
             m_state = bus.abort ? 0 : 2;
           end
        2: if (bus.abort) begin
             m_state = 0;
           end else if (bus.en) begin
             m_dout = m_xf(m_dout, m_mode);
             m_cnt++;
             if (m_cnt == m_len) m_state = 3;
           end
        3, 4: if (bus.ack) m_state = 0;
        default: m_state = 0;
      endcase
    end
  endtask

  // One clock: model follows the same sampled inputs, outputs checked #1 later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("state", 32'(bus.state), m_state);
    check_val("cnt",   32'(bus.cnt),   m_cnt);
    check_val("dout",  32'(bus.dout),  m_dout);
    check_val("busy",  32'(bus.busy),  (m_state == 1 || m_state == 2) ? 1 : 0);
    check_val("done",  32'(bus.done),  (m_state == 3) ? 1 : 0);
    check_val("err",   32'(bus.err),   (m_state == 4) ? 1 : 0);
  endtask

  task automatic drive_start(input logic [7:0] d, input logic [1:0] md);
    bus.start = 1'b1;
    bus.din   = d;
    bus.mode  = md;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_d;
    int n_en;
    bus.start = 1'b0; bus.abort = 1'b0; bus.en = 1'b0; bus.ack = 1'b0;
    bus.mode  = 2'b00; bus.din = '0;

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    check_val("rst_state", 32'(bus.state), 0);
    rst_n = 1'b1;

    // Rotate run, len=3 seed 0x03: start edge is cycle 1, done on cycle 5
    bus.en = 1'b1;
    drive_start(8'h03, 2'b01);
    check_val("t1_load", 32'(bus.state), 1);
    tick();
    tick(); check_val("t1_d0", 32'(bus.dout), 'h06);
    tick(); check_val("t1_d1", 32'(bus.dout), 'h0C);
            check_val("t1_nodone", 32'(bus.done), 0);
    tick(); check_val("t1_d2", 32'(bus.dout), 'h18);
            check_val("t1_done", 32'(bus.done), 1);
    bus.ack = 1'b1;
    tick(); check_val("t1_idle", 32'(bus.state), 0);
    bus.ack = 1'b0;

    // Zero length -> ERR; ack returns, a second ack does nothing
    drive_start(8'h00, 2'b00);
    check_val("t2_err",  32'(bus.err),  1);
    check_val("t2_busy", 32'(bus.busy), 0);
    bus.ack = 1'b1;
    tick(); check_val("t2_idle", 32'(bus.state), 0);
    tick(); check_val("t2_idle2", 32'(bus.state), 0);
    bus.ack = 1'b0;

    // Invert run, len=4 seed 0xA4, en toggling; dout flips only when enabled
    drive_start(8'hA4, 2'b10);
    tick();
    exp_d = 'hA4;
    n_en  = 0;
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) begin
      bus.en = (i % 2 == 0);
      if (bus.en) begin
        exp_d = (exp_d == 'hA4) ? 'h5B : 'hA4;
        n_en++;
      end
      tick();
      check_val("t3_dout", 32'(bus.dout), exp_d);
    end
    check_val("t3_done",   32'(bus.done), 1);
    check_val("t3_en_cnt", n_en, 4);
    check_val("t3_final",  32'(bus.dout), 'hA4);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;

    // Abort in RUN at cnt=2
    bus.en = 1'b1;
    drive_start(8'h06, 2'b00);
    tick(); tick(); tick();
    check_val("t4_cnt2", 32'(bus.cnt), 2);
    bus.abort = 1'b1;
    tick();
    check_val("t4_idle", 32'(bus.state), 0);
    check_val("t4_hold", 32'(bus.cnt), 2);
    bus.abort = 1'b0;

    // LFSR len=1, then start+ack together in DONE: no capture
    drive_start(8'h01, 2'b11);
    tick(); tick();
    check_val("t4_lfsr", 32'(bus.dout), 'h02);
    bus.start = 1'b1; bus.ack = 1'b1; bus.din = 8'h55; bus.mode = 2'b10;
    tick();
    check_val("t4_sa_idle", 32'(bus.state), 0);
    check_val("t4_sa_dout", 32'(bus.dout), 'h02);
    bus.start = 1'b0; bus.ack = 1'b0;
    tick();
    check_val("t4_nocap", 32'(bus.state), 0);

    // Reset mid-run at cnt=3, and reset with start held
    drive_start(8'h08, 2'b01);
    tick(); tick(); tick(); tick();
    check_val("t5_cnt3", 32'(bus.cnt), 3);
    rst_n = 1'b0;
    tick();
    check_val("t5_state", 32'(bus.state), 0);
    check_val("t5_cnt",   32'(bus.cnt),   0);
    check_val("t5_dout",  32'(bus.dout),  0);
    bus.start = 1'b1; bus.din = 8'h03;
    tick();
    check_val("t5_rst_start", 32'(bus.state), 0);
    bus.start = 1'b0;
    rst_n = 1'b1;

    // Maximum length: cnt reaches 2^CNT_W-1 without wrapping
    drive_start(8'h1F, 2'b01);
    for (int i = 0; i < 40 && bus.done !== 1'b1; i++) tick();
    check_val("t6_done", 32'(bus.done), 1);
    check_val("t6_cnt",  32'(bus.cnt),  CMOD - 1);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.abort = ($urandom_range(0, 19) == 0);
      bus.en    = ($urandom_range(0, 3) != 0);
      bus.ack   = ($urandom_range(0, 2) == 0);
      bus.mode  = 2'($urandom_range(0, 3));
      bus.din   = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        bus.din = 8'((int'(bus.din) & 'hE0) | int'($urandom_range(0, 6)));
      tick();
    end
    rst_n = 1'b1;

`ifdef SCAN_CHAIN_EN
    begin
      logic pat [CHAIN_W];
      scan_en = 1'b1; bus.start = 1'b1; bus.en = 1'b1;
      for (int k = 0; k < CHAIN_W; k++) begin
        pat[k]  = 1'($urandom_range(0, 1));
        scan_in = pat[k];
        @(posedge clk); #1;
      end
      for (int k = 0; k < CHAIN_W; k++) begin
        check_val("scan_out", 32'(scan_out), 32'(pat[k]));
        scan_in = 1'b0;
        @(posedge clk); #1;
      end
      scan_en = 1'b0; bus.start = 1'b0; bus.en = 1'b0;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_crest_seq_fsm
`default_nettype wire
